// File: rtl/piso_bit_streamer.sv
// piso_bit_streamer: parallel-in serial-out bit streamer with valid/ready word input
module piso_bit_streamer #(
  parameter int DATA_W = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              frame_done,
  output logic              busy,
  output logic [CNT_W-1:0]  frames_sent
);
  localparam int IW = $clog2(DATA_W);
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [IW-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt_n;
  logic last, hs;
  assign busy = state == SHIFT;
  assign last = busy && idx == LAST;
  assign s_ready = rst && !flush && (!busy || last);
  assign hs = s_valid && s_ready;
  assign bit_valid = busy;
  assign frame_done = last;
  assign bit_out = busy ? (MSB_FIRST ? shreg[DATA_W-1] : shreg[0]) : IDLE_BIT;
  // next-state: flush aborts, handshake (re)loads, last bit closes the frame
  always_comb begin
    state_n = flush ? IDLE : hs ? SHIFT : last ? IDLE : state;
    idx_n = (flush || hs || last) ? '0 : busy ? idx + 1'b1 : idx;
    shreg_n = hs ? s_data : busy ? (MSB_FIRST ? shreg << 1 : shreg >> 1) : shreg;
    cnt_n = frames_sent + CNT_W'(last && !flush);
  end
  // state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      idx <= '0;
      frames_sent <= '0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      idx <= idx_n;
      frames_sent <= cnt_n;
    end
  end
endmodule

// File: tb/tb_piso_bit_streamer.sv
// tb_piso_bit_streamer: directed plus random checks of two streamer configurations against a word-level model
module tb_piso_bit_streamer;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic rdy1, bo1, bv1, fd1, by1, rdy2, bo2, bv2, fd2, by2;
  logic [15:0] fs1;
  logic [1:0] fs2;
  int n = 0, fails = 0;
  bit act = 0, rstm = 0;
  logic [7:0] word = '0;
  int pos = 0, cnt1 = 0, cnt2 = 0;

  piso_bit_streamer dut (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(rdy1), .s_data(s_data),
    .bit_out(bo1), .bit_valid(bv1), .frame_done(fd1), .busy(by1), .frames_sent(fs1)
  );
  piso_bit_streamer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(rdy2), .s_data(s_data),
    .bit_out(bo2), .bit_valid(bv2), .frame_done(fd2), .busy(by2), .frames_sent(fs2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic check_all();
    bit rdy, l;
    l = act && pos == 7;
    rdy = rstm && !flush && (!act || l);
    chk("s_ready", rdy1, rdy);
    chk("s_ready2", rdy2, rdy);
    chk("bit_valid", bv1, act);
    chk("bit_valid2", bv2, act);
    chk("busy", by1, act);
    chk("bit_out_msb", bo1, act ? word[7-pos] : 1'b0);
    chk("bit_out_lsb", bo2, act ? word[pos] : 1'b1);
    chk("frame_done", fd1, l);
    chk("frame_done2", fd2, l);
    chk("frames_sent", fs1, cnt1);
    chk("frames_sent2", fs2, cnt2);
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit f);
    bit l, hs;
    s_valid = v;
    s_data = d;
    flush = f;
    #1;
    check_all();
    l = act && pos == 7;
    hs = v && rstm && !f && (!act || l);
    if (f) begin
      act = 0;
      pos = 0;
    end else begin
      if (l) begin
        cnt1 = (cnt1 + 1) % 65536;
        cnt2 = (cnt2 + 1) % 4;
      end
      if (hs) begin
        act = 1;
        word = d;
        pos = 0;
      end else if (act && pos < 7) pos++;
      else act = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    act = 0; pos = 0; cnt1 = 0; cnt2 = 0; rstm = 0;
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    rstm = 1;
  endtask

  initial begin
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    rstm = 1;
    cyc(0, 8'h00, 0);
    cyc(1, 8'hB6, 0);
    repeat (10) cyc(0, 8'h55, 0);
    cyc(1, 8'hB0, 0);
    repeat (8) cyc(1, 8'h0B, 0);
    repeat (9) cyc(0, 8'h00, 0);
    cyc(1, 8'h0D, 0);
    repeat (9) cyc(0, 8'hFF, 0);
    cyc(1, 8'hA5, 0);
    repeat (3) cyc(0, 8'h00, 0);
    cyc(1, 8'h3C, 1);
    repeat (3) cyc(0, 8'h00, 0);
    cyc(1, 8'h81, 0);
    repeat (7) cyc(0, 8'h00, 0);
    cyc(1, 8'h66, 1);
    repeat (2) cyc(0, 8'h00, 0);
    cyc(1, 8'hC3, 0);
    repeat (5) cyc(0, 8'h00, 0);
    pulse_reset();
    cyc(1, 8'hFF, 0);
    repeat (9) cyc(0, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'(i * 37), 0);
      repeat (7) cyc(0, 8'h00, 0);
    end
    repeat (2) cyc(0, 8'h00, 0);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), $urandom_range(0, 19) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, fails);
    $finish;
  end
endmodule
